// File: rtl/oled_cmd_sequencer.sv
// rtl/oled_cmd_sequencer.sv - microcoded SPI OLED command sequencer; define OLED_SEQ_STREAM_EN for the STREAM opcode
module oled_cmd_sequencer #(
    parameter int ADDR_W     = 8,
    parameter int DLY_W      = 24,
    parameter int LOOP_W     = 15,
    parameter int LOOP_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [39:0]       rom_data,
    output logic [7:0]        spi_data,
    output logic              spi_wr,
    input  logic              spi_busy,
    input  logic              spi_done,
    output logic              oled_vdd,
    output logic              oled_vbat,
    output logic              oled_res,
    output logic              oled_dc,
    output logic              busy,
    output logic              done,
    output logic              error
`ifdef OLED_SEQ_STREAM_EN
    ,
    input  logic [7:0]        pix_data,
    input  logic              pix_valid,
    output logic              pix_ready
`endif
);

    localparam logic [3:0] OP_NOP     = 4'd0;
    localparam logic [3:0] OP_PINS    = 4'd1;
    localparam logic [3:0] OP_SEND    = 4'd2;
    localparam logic [3:0] OP_DELAY   = 4'd3;
    localparam logic [3:0] OP_LOOP    = 4'd4;
    localparam logic [3:0] OP_ENDLOOP = 4'd5;
    localparam logic [3:0] OP_JUMP    = 4'd6;
    localparam logic [3:0] OP_HALT    = 4'd7;
`ifdef OLED_SEQ_STREAM_EN
    localparam logic [3:0] OP_STREAM  = 4'd8;
`endif

    // Stack storage is rounded up to a power of two so the pointer indexes it without range gaps.
    localparam int SP_W  = $clog2(LOOP_DEPTH + 1);
    localparam int STK_N = 1 << SP_W;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_SEND_REQ,
        S_SEND_WAIT,
        S_DELAY,
        S_HALT,
        S_ERROR
`ifdef OLED_SEQ_STREAM_EN
        ,
        S_STREAM,
        S_STREAM_WAIT
`endif
    } state_t;

    state_t            state;
    state_t            state_d;
    logic [ADDR_W-1:0] pc;
    logic [DLY_W-1:0]  dly_cnt;
    logic [SP_W-1:0]   sp;
    logic [SP_W-1:0]   top;
    logic [ADDR_W-1:0] stk_pc  [STK_N];
    logic [LOOP_W-1:0] stk_cnt [STK_N];
    logic [3:0]        opcode;
    logic [DLY_W-1:0]  dly_arg;
    logic [LOOP_W-1:0] loop_arg;
    logic              stack_full;
    logic              stack_empty;
    logic              loop_again;
    logic              unused_bits;
`ifdef OLED_SEQ_STREAM_EN
    logic [15:0]       str_cnt;
`endif

    assign opcode      = rom_data[39:36];
    assign dly_arg     = rom_data[DLY_W-1:0];
    assign loop_arg    = rom_data[LOOP_W-1:0];
    assign top         = sp - 1'b1;
    assign stack_full  = (sp == SP_W'(LOOP_DEPTH));
    assign stack_empty = (sp == '0);
    assign loop_again  = (stk_cnt[top] > LOOP_W'(1));
    assign rom_addr    = pc;
    assign unused_bits = ^rom_data;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_d;
    end

    // Next-state decode; start overrides everything and restarts at address 0.
    always_comb begin
        state_d = state;
        if (start) begin
            state_d = S_FETCH;
        end else begin
            case (state)
                S_FETCH: state_d = S_EXEC;
                S_EXEC: begin
                    case (opcode)
                        OP_NOP, OP_PINS, OP_JUMP: state_d = S_FETCH;
                        OP_SEND:    state_d = S_SEND_REQ;
                        OP_DELAY:   state_d = (dly_arg == '0) ? S_FETCH : S_DELAY;
                        OP_LOOP:    state_d = stack_full ? S_ERROR : S_FETCH;
                        OP_ENDLOOP: state_d = stack_empty ? S_ERROR : S_FETCH;
                        OP_HALT:    state_d = S_HALT;
`ifdef OLED_SEQ_STREAM_EN
                        OP_STREAM:  state_d = (rom_data[15:0] == 16'd0) ? S_FETCH : S_STREAM;
`endif
                        default:    state_d = S_ERROR;
                    endcase
                end
                S_SEND_REQ:  if (!spi_busy) state_d = S_SEND_WAIT;
                S_SEND_WAIT: if (spi_done) state_d = S_FETCH;
                S_DELAY:     if (dly_cnt == '0) state_d = S_FETCH;
`ifdef OLED_SEQ_STREAM_EN
                S_STREAM:    if (pix_valid && pix_ready) state_d = S_STREAM_WAIT;
                S_STREAM_WAIT: begin
                    if (spi_done) state_d = (str_cnt == 16'd1) ? S_FETCH : S_STREAM;
                end
`endif
                default: state_d = state;
            endcase
        end
    end

    // Status outputs derived from the current state.
    always_comb begin
        busy = !(state == S_IDLE || state == S_HALT || state == S_ERROR);
`ifdef OLED_SEQ_STREAM_EN
        pix_ready = (state == S_STREAM) && !spi_busy && !start;
`endif
    end

    // Datapath: program counter, pins, SPI byte/strobe, delay counter, stack pointer, status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= '0;
            dly_cnt   <= '0;
            sp        <= '0;
            spi_data  <= 8'h00;
            spi_wr    <= 1'b0;
            oled_vdd  <= 1'b1;
            oled_vbat <= 1'b1;
            oled_res  <= 1'b0;
            oled_dc   <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
`ifdef OLED_SEQ_STREAM_EN
            str_cnt   <= 16'd0;
`endif
        end else begin
            spi_wr <= 1'b0;
            if (start) begin
                pc    <= '0;
                sp    <= '0;
                done  <= 1'b0;
                error <= 1'b0;
            end else begin
                case (state)
                    S_EXEC: begin
                        case (opcode)
                            OP_NOP: pc <= pc + 1'b1;
                            OP_PINS: begin
                                {oled_vdd, oled_vbat, oled_res, oled_dc} <= rom_data[3:0];
                                pc <= pc + 1'b1;
                            end
                            OP_SEND: begin
                                oled_dc  <= rom_data[8];
                                spi_data <= rom_data[7:0];
                            end
                            OP_DELAY: begin
                                if (dly_arg == '0) pc <= pc + 1'b1;
                                else               dly_cnt <= dly_arg - 1'b1;
                            end
                            OP_LOOP: begin
                                if (!stack_full) begin
                                    sp <= sp + 1'b1;
                                    pc <= pc + 1'b1;
                                end
                            end
                            OP_ENDLOOP: begin
                                if (!stack_empty) begin
                                    if (loop_again) begin
                                        pc <= stk_pc[top];
                                    end else begin
                                        sp <= sp - 1'b1;
                                        pc <= pc + 1'b1;
                                    end
                                end
                            end
                            OP_JUMP: pc <= rom_data[ADDR_W-1:0];
                            OP_HALT: done <= 1'b1;
`ifdef OLED_SEQ_STREAM_EN
                            OP_STREAM: begin
                                oled_dc <= 1'b1;
                                if (rom_data[15:0] == 16'd0) pc <= pc + 1'b1;
                                else                         str_cnt <= rom_data[15:0];
                            end
`endif
                            default: ;
                        endcase
                    end
                    S_SEND_REQ:  if (!spi_busy) spi_wr <= 1'b1;
                    S_SEND_WAIT: if (spi_done) pc <= pc + 1'b1;
                    S_DELAY: begin
                        if (dly_cnt == '0) pc <= pc + 1'b1;
                        else               dly_cnt <= dly_cnt - 1'b1;
                    end
`ifdef OLED_SEQ_STREAM_EN
                    S_STREAM: begin
                        if (pix_valid && pix_ready) begin
                            spi_data <= pix_data;
                            spi_wr   <= 1'b1;
                        end
                    end
                    S_STREAM_WAIT: begin
                        if (spi_done) begin
                            if (str_cnt == 16'd1) pc <= pc + 1'b1;
                            else                  str_cnt <= str_cnt - 1'b1;
                        end
                    end
`endif
                    default: ;
                endcase
                // Any fault parks the panel in reset; supplies are left alone.
                if (state_d == S_ERROR && state != S_ERROR) begin
                    error    <= 1'b1;
                    oled_res <= 1'b0;
                end
            end
        end
    end

    // Loop stack entries; only slots below sp are ever read, so they need no reset.
    always_ff @(posedge clk) begin
        if (!start && state == S_EXEC) begin
            if (opcode == OP_LOOP && !stack_full) begin
                stk_pc[sp]  <= pc + 1'b1;
                stk_cnt[sp] <= (loop_arg == '0) ? LOOP_W'(1) : loop_arg;
            end else if (opcode == OP_ENDLOOP && !stack_empty && loop_again) begin
                stk_cnt[top] <= stk_cnt[top] - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_oled_cmd_sequencer.sv
// tb/tb_oled_cmd_sequencer.sv - directed scoreboard bench for oled_cmd_sequencer
module tb_oled_cmd_sequencer;

    localparam logic [3:0] OP_NOP     = 4'd0;
    localparam logic [3:0] OP_PINS    = 4'd1;
    localparam logic [3:0] OP_SEND    = 4'd2;
    localparam logic [3:0] OP_DELAY   = 4'd3;
    localparam logic [3:0] OP_LOOP    = 4'd4;
    localparam logic [3:0] OP_ENDLOOP = 4'd5;
    localparam logic [3:0] OP_JUMP    = 4'd6;
    localparam logic [3:0] OP_HALT    = 4'd7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rom_addr;
    logic [39:0] rom_data = '0;
    logic [7:0]  spi_data;
    logic        spi_wr;
    logic        spi_busy = 1'b0;
    logic        spi_done = 1'b0;
    logic        oled_vdd, oled_vbat, oled_res, oled_dc;
    logic        busy, done, error;
`ifdef OLED_SEQ_STREAM_EN
    logic [7:0]  pix_data = 8'h00;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
`endif

    logic [39:0] rom [256];
    logic        force_busy = 1'b0;
    int          spi_cnt = 0;
    logic        wr_prev = 1'b0;
    int          wr_long = 0;
    logic [8:0]  got_q [$];
    logic [8:0]  exp_q [$];
    int          got_rd = 0;
    int          total = 0;
    int          bad = 0;

    oled_cmd_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .spi_data(spi_data), .spi_wr(spi_wr), .spi_busy(spi_busy), .spi_done(spi_done),
        .oled_vdd(oled_vdd), .oled_vbat(oled_vbat), .oled_res(oled_res), .oled_dc(oled_dc),
        .busy(busy), .done(done), .error(error)
`ifdef OLED_SEQ_STREAM_EN
        , .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous instruction ROM.
    always @(posedge clk) rom_data <= rom[rom_addr];

    // spi_master stand-in plus output monitor: captures each strobe, then busy for 4 cycles and a done pulse.
    always @(negedge clk) begin
        if (spi_wr) begin
            got_q.push_back({oled_dc, spi_data});
            if (wr_prev) wr_long = wr_long + 1;
        end
        wr_prev  = spi_wr;
        spi_done = 1'b0;
        if (spi_cnt != 0) begin
            spi_cnt = spi_cnt - 1;
            if (spi_cnt == 0) spi_done = 1'b1;
        end else if (spi_wr) begin
            spi_cnt = 4;
        end
        spi_busy = force_busy || (spi_cnt != 0);
    end

    function automatic logic [39:0] ins(input logic [3:0] op, input logic [31:0] arg);
        return {op, 4'h0, arg};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = ins(OP_HALT, 32'd0);
    endtask

    // Returns one time unit after the clock edge that samples start.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int max, output int n);
        n = 0;
        while (!done && !error && n < max) begin
            @(posedge clk);
            #1 n = n + 1;
        end
        chk({tag, "_finished"}, 64'(n < max), 64'd1);
    endtask

    task automatic check_bytes(input string tag);
        int         got_n;
        logic [8:0] e;
        logic [8:0] g;
        got_n = got_q.size() - got_rd;
        chk({tag, "_nbytes"}, 64'(got_n), 64'(exp_q.size()));
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (got_rd < got_q.size()) begin
                g = got_q[got_rd];
                got_rd = got_rd + 1;
            end else begin
                g = 'x;
            end
            chk({tag, "_byte"}, 64'(g), 64'(e));
        end
        got_rd = got_q.size();
        chk({tag, "_wr_one_cycle"}, 64'(wr_long), 64'd0);
    endtask

    initial begin
        int n;
        clear_rom();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_flags", 64'({oled_vdd, oled_vbat, oled_res, oled_dc, spi_wr, busy, done, error}), 64'h C0);
        chk("rst_data", 64'(spi_data), 64'h0);
        chk("rst_addr", 64'(rom_addr), 64'h0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);

        // T1: reset while a SEND is pending, then a clean run from address 0.
        rom[0] = ins(OP_SEND, 32'h177);
        rom[1] = ins(OP_HALT, 32'd0);
        force_busy = 1'b1;
        pulse_start();
        repeat (6) @(posedge clk);
        #1;
        chk("t1_pending_data", 64'({oled_dc, spi_data}), 64'h177);
        chk("t1_pending_nowr", 64'(got_q.size() - got_rd), 64'd0);
        @(negedge clk) rst_n = 1'b0;
        #1;
        chk("t1_rst_flags", 64'({oled_vdd, oled_vbat, oled_res, oled_dc, spi_wr, busy, done, error}), 64'h C0);
        chk("t1_rst_data", 64'(spi_data), 64'h0);
        chk("t1_rst_addr", 64'(rom_addr), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        force_busy = 1'b0;
        repeat (3) @(negedge clk);
        chk("t1_idle_after_rst", 64'(busy), 64'd0);
        exp_q.push_back(9'h177);
        pulse_start();
        wait_end("t1", 300, n);
        chk("t1_status", 64'({done, error, busy}), 64'b100);
        check_bytes("t1");

        // T2: pins, delay, one command byte, halt.
        clear_rom();
        rom[0] = ins(OP_PINS, 32'hE);
        rom[1] = ins(OP_DELAY, 32'd10);
        rom[2] = ins(OP_SEND, 32'h0AF);
        exp_q.push_back(9'h0AF);
        pulse_start();
        @(posedge clk);
        #1 chk("t2_res_cycle1", 64'(oled_res), 64'd0);
        @(posedge clk);
        #1 chk("t2_res_cycle2", 64'(oled_res), 64'd1);
        wait_end("t2", 300, n);
        chk("t2_status", 64'({done, error, busy}), 64'b100);
        chk("t2_pins", 64'({oled_vdd, oled_vbat, oled_res, oled_dc}), 64'b1110);
        check_bytes("t2");

        // DELAY timing: instruction takes arg+2 cycles, HALT decode 2 more.
        clear_rom();
        rom[0] = ins(OP_DELAY, 32'd5);
        pulse_start();
        wait_end("dly5", 100, n);
        chk("dly5_cycles", 64'(n), 64'd9);
        rom[0] = ins(OP_DELAY, 32'd0);
        pulse_start();
        wait_end("dly0", 100, n);
        chk("dly0_cycles", 64'(n), 64'd4);

        // T3: nested loops 3 x 2 sends.
        clear_rom();
        rom[0] = ins(OP_LOOP, 32'd3);
        rom[1] = ins(OP_LOOP, 32'd2);
        rom[2] = ins(OP_SEND, 32'h000);
        rom[3] = ins(OP_ENDLOOP, 32'd0);
        rom[4] = ins(OP_ENDLOOP, 32'd0);
        for (int i = 0; i < 6; i++) exp_q.push_back(9'h000);
        pulse_start();
        wait_end("t3", 2000, n);
        chk("t3_status", 64'({done, error, busy}), 64'b100);
        check_bytes("t3");

        // LOOP 0 runs the body once.
        clear_rom();
        rom[0] = ins(OP_LOOP, 32'd0);
        rom[1] = ins(OP_SEND, 32'h15A);
        rom[2] = ins(OP_ENDLOOP, 32'd0);
        exp_q.push_back(9'h15A);
        pulse_start();
        wait_end("loop0", 500, n);
        chk("loop0_status", 64'({done, error, busy}), 64'b100);
        check_bytes("loop0");

        // T4: stack overflow on the third LOOP.
        clear_rom();
        rom[0] = ins(OP_PINS, 32'hE);
        rom[1] = ins(OP_LOOP, 32'd2);
        rom[2] = ins(OP_LOOP, 32'd2);
        rom[3] = ins(OP_LOOP, 32'd2);
        pulse_start();
        wait_end("t4", 200, n);
        chk("t4_status", 64'({done, error, busy}), 64'b010);
        chk("t4_pins", 64'({oled_vdd, oled_vbat, oled_res}), 64'b110);
        chk("t4_addr", 64'(rom_addr), 64'd3);
        repeat (5) @(posedge clk);
        #1 chk("t4_addr_frozen", 64'(rom_addr), 64'd3);

        // ENDLOOP on an empty stack, and an illegal opcode.
        clear_rom();
        rom[0] = ins(OP_ENDLOOP, 32'd0);
        pulse_start();
        wait_end("endloop_empty", 100, n);
        chk("endloop_empty_status", 64'({done, error, rom_addr}), 64'({2'b01, 8'd0}));
        rom[0] = ins(OP_NOP, 32'd0);
        rom[1] = ins(4'hF, 32'd0);
        pulse_start();
        wait_end("illegal", 100, n);
        chk("illegal_status", 64'({done, error, rom_addr}), 64'({2'b01, 8'd1}));

        // PC wrap: 255 -> 0 re-executes LOOP until the stack overflows.
        clear_rom();
        rom[0] = ins(OP_LOOP, 32'd1);
        rom[1] = ins(OP_JUMP, 32'd255);
        rom[255] = ins(OP_SEND, 32'h142);
        exp_q.push_back(9'h142);
        exp_q.push_back(9'h142);
        pulse_start();
        wait_end("wrap", 500, n);
        chk("wrap_status", 64'({done, error, rom_addr}), 64'({2'b01, 8'd0}));
        check_bytes("wrap");

        // T5: SPI held busy for 50 cycles at a SEND.
        clear_rom();
        rom[0] = ins(OP_SEND, 32'h13C);
        force_busy = 1'b1;
        pulse_start();
        repeat (50) @(posedge clk);
        #1;
        chk("t5_held_nowr", 64'(got_q.size() - got_rd), 64'd0);
        chk("t5_held_busy", 64'(busy), 64'd1);
        force_busy = 1'b0;
        exp_q.push_back(9'h13C);
        wait_end("t5", 300, n);
        chk("t5_status", 64'({done, error, busy}), 64'b100);
        check_bytes("t5");

        // Restart while running: abort a long delay and run from 0 again.
        clear_rom();
        rom[0] = ins(OP_DELAY, 32'd1000);
        pulse_start();
        repeat (10) @(posedge clk);
        #1 chk("restart_running", 64'(busy), 64'd1);
        rom[0] = ins(OP_NOP, 32'd0);
        pulse_start();
        chk("restart_addr", 64'(rom_addr), 64'd0);
        wait_end("restart", 100, n);
        chk("restart_cycles", 64'(n), 64'd4);
        chk("restart_status", 64'({done, error}), 64'b10);

`ifdef OLED_SEQ_STREAM_EN
        // T6: STREAM 4 pixel bytes with a randomly stalling source.
        clear_rom();
        rom[0] = ins(4'd8, 32'd4);
        rom[1] = ins(OP_SEND, 32'h055);
        for (int k = 1; k <= 4; k++) exp_q.push_back({1'b1, 8'(8'h11 * k)});
        exp_q.push_back(9'h055);
        pulse_start();
        fork
            begin
                for (int k = 1; k <= 4; k++) begin
                    int   tries;
                    logic hs;
                    tries = 0;
                    hs = 1'b0;
                    pix_data = 8'(8'h11 * k);
                    while (!hs && tries < 500) begin
                        @(negedge clk);
                        pix_valid = 1'($urandom_range(0, 1));
                        #2 hs = pix_valid && pix_ready;
                        tries = tries + 1;
                        @(posedge clk);
                    end
                end
                @(negedge clk) pix_valid = 1'b0;
            end
            begin
                wait_end("t6", 4000, n);
            end
        join
        chk("t6_status", 64'({done, error, busy}), 64'b100);
        check_bytes("t6");
`else
        // Opcode 8 is illegal without the stream option.
        clear_rom();
        rom[0] = ins(4'd8, 32'd4);
        pulse_start();
        wait_end("op8", 100, n);
        chk("op8_status", 64'({done, error, rom_addr}), 64'({2'b01, 8'd0}));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
